// File: rtl/alu_share_ctrl.sv
// Two-requester front end for one shared combinational 32-bit ALU: round-robin accept,
// one execute cycle, then a held result returned over a per-requester valid/ready handshake.
module alu_share_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [31:0]      resp_r,
    output logic [3:0]       resp_flags,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [31:0]      alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        r_q, r_d;
    logic [3:0]         f_q, f_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               gnt0, gnt1, hs;
    logic [3:0]         flag_mask;

    // A tie goes to whichever requester was not granted last; reset holds off any accept.
    assign gnt0 = (state_q == StIdle) & ~rst & req0_valid & (~req1_valid | last_q);
    assign gnt1 = (state_q == StIdle) & ~rst & req1_valid & (~req0_valid | ~last_q);
    assign hs   = (state_q == StResp) & (owner_q ? resp1_ready : resp0_ready);

    // Flag bit order {zero, carry, negative, overflow}.
    always_comb begin
        flag_mask = 4'b0000;
        unique case (op_q)
            4'b0000, 4'b0001,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: flag_mask = 4'b1110;
            4'b0010, 4'b0011:                   flag_mask = 4'b1011;
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1010, 4'b1011:                   flag_mask = 4'b1010;
            default:                            flag_mask = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        r_d     = r_q;
        f_d     = f_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        unique case (state_q)
            StIdle: begin
                if (gnt0 | gnt1) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    a_d     = gnt1 ? req1_a  : req0_a;
                    b_d     = gnt1 ? req1_b  : req0_b;
                    op_d    = gnt1 ? req1_op : req0_op;
                    state_d = StExec;
                end
            end
            StExec: begin
                r_d     = alu_r;
                f_d     = {alu_zero, alu_carry, alu_negative, alu_overflow} & flag_mask;
                state_d = StResp;
            end
            StResp: begin
                if (hs) begin
                    if (!owner_q && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
                    if (owner_q && cnt1_q != '1)  cnt1_d = cnt1_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            r_q     <= '0;
            f_q     <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            r_q     <= r_d;
            f_q     <= f_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign resp0_valid = (state_q == StResp) & ~owner_q;
    assign resp1_valid = (state_q == StResp) & owner_q;
    assign resp_r      = r_q;
    assign resp_flags  = f_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_aluc    = op_q;
    assign busy        = (state_q != StIdle);
    assign cnt0        = cnt0_q;
    assign cnt1        = cnt1_q;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester controller that shares one 32-bit ALU instance (4-bit aluc opcode, r plus zero/carry/negative/overflow flags).
- Arbitrates round-robin, latches operands, and drives the ALU for one cycle.
- Captures the result with flags masked to those meaningful for the opcode, and returns it through a per-requester valid/ready response handshake.
- Sits between the CPU execute stage / test master and the shared ALU; also keeps per-requester operation counts.

Parameters:
- CNT_W, 16, width of the saturating per-requester completed-operation counters.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle when valid&ready
req0_a  in  32  requester 0 operand a
req0_b  in  32  requester 0 operand b
req0_op  in  4  requester 0 aluc opcode
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
resp0_valid  out  1  result pending for requester 0
resp0_ready  in  1  requester 0 takes result
resp1_valid  out  1  result pending for requester 1
resp1_ready  in  1  requester 1 takes result
resp_r  out  32  captured result (shared by both responders)
resp_flags  out  4  {zero,carry,negative,overflow}, masked
alu_a  out  32  to ALU a
alu_b  out  32  to ALU b
alu_aluc  out  4  to ALU aluc
alu_r  in  32  from ALU r
alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  from ALU flags
busy  out  1  state != IDLE
cnt0  out  CNT_W  ops completed for requester 0
cnt1  out  CNT_W  ops completed for requester 1

Behaviour:
- Reset: state=IDLE.
  - All outputs 0: alu_a, alu_b, alu_aluc, resp_r, resp_flags, respX_valid, cnt0, cnt1.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational.
    - Only one valid: that requester gets ready.
    - Both valid: the requester != last_grant gets ready, the other gets 0.
    - Neither valid: both 0.
  - reqX_ready is never asserted outside IDLE.
  - On accept (cycle N): latch a/b/op into alu_a/alu_b/alu_aluc, record the owner, set last_grant=owner, go to EXEC.
- EXEC (cycle N+1):
  - ALU inputs are stable from the latches; the ALU is combinational.
  - At the end of the cycle, capture resp_r=alu_r and resp_flags=masked flags, then go to RESP.
- RESP (from cycle N+2):
  - resp_valid of the owner is 1; the other responder's valid stays 0.
  - resp_r and resp_flags are held stable until the owner's resp_ready=1.
  - On handshake: increment the owner's counter (saturates at all-ones, no wrap) and return to IDLE.
  - The next accept is possible in the cycle after the handshake (no same-cycle re-accept).
- Minimum latency: accept to resp_valid = 2 cycles. Minimum throughput: one op per 3 cycles.
- Flag mask by opcode (masked bits forced to 0):
  - 0000, 0001 (unsigned add/sub): zero, carry, negative.
  - 0010, 0011 (signed add/sub): zero, negative, overflow.
  - 0100-0111 (and/or/xor/nor), 1010, 1011 (sltu/slt): zero, negative.
  - 1000, 1001 (lui): all flags 0.
  - 1100-1111 (shifts): zero, carry, negative.
- alu_a, alu_b and alu_aluc hold their last values in IDLE and RESP; no toggling without a new accept.
- Requester inputs change freely while not accepted; only values sampled at accept matter.
- resp_ready of the non-owner is ignored.
- Reset in any state (including EXEC or RESP):
  - Pending op discarded, respX_valid=0 next cycle, counters cleared, last_grant=1.
- Simultaneous rst and handshake: reset wins, no count.
- busy is 1 in EXEC and RESP.

Test Plan:
- Single op: req0 a=0x00000005, b=0x00000003, op=0000 at cycle 2 → alu_aluc=0000 at cycle 3; resp0_valid cycle 4 with resp_r=0x00000008, flags=0000; cnt0=1 after handshake.
- Tie / round-robin: both valid every cycle from reset, resp ready tied 1 → grant order 0,1,0,1; resp1 never valid while owner=0; cnt0=cnt1=2 after four ops.
- Flag mask:
  - op=0010, a=0x7FFFFFFF, b=1 → resp_r=0x80000000, flags=0011 (negative, overflow).
  - op=1000, b=0x0000FFFF → resp_r=0xFFFF0000, flags=0000.
- Backpressure: resp0_ready held 0 for 5 cycles → resp_r/resp_flags stable, req1_ready=0 the whole time though req1_valid=1; req1 accepted the cycle after the handshake.
- Reset mid-op: assert rst in EXEC → next cycle all outputs 0, busy=0; first op afterwards granted to req0 on a tie.
- Counter saturation (CNT_W=2): five req0 ops → cnt0 = 3, 3 held, no wrap.
